// File: rtl/pwm_multi_pkg.sv
// ---------------------------------------------------------------------------
// pwm_multi_pkg
// Shared definitions for the multi-channel pulse generator:
//   - state_t      : per-channel FSM states (IDLE, LOW, HIGH)
//   - OFS_*        : register offsets from a channel's base address
//   - CTRL_/STAT_* : bit positions inside the CTRL and STATUS bytes
//   - DEF_*        : values loaded by the init strobe
//   - get_byte/put_byte : little-endian byte access into a 32-bit word
// Optional feature macro used by the design: PWM_BURST_EN
// ---------------------------------------------------------------------------
package pwm_multi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [3:0] OFS_CTRL  = 4'd0;
    localparam logic [3:0] OFS_STAT  = 4'd1;
    localparam logic [3:0] OFS_ZERO  = 4'd4;
    localparam logic [3:0] OFS_SIG   = 4'd8;
    localparam logic [3:0] OFS_BURST = 4'd12;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_INV     = 2;
    localparam int CTRL_SRST    = 7;

    localparam int STAT_RUN  = 0;
    localparam int STAT_HIGH = 1;
    localparam int STAT_DONE = 2;

    localparam logic [31:0] DEF_ZERO   = 32'd0;
    localparam logic [31:0] DEF_SIGNAL = 32'd16;

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] t;
        t = w;
        t[{idx, 3'b000} +: 8] = b;
        return t;
    endfunction

endpackage

// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One pulse-generator channel: CTRL/STATUS/ZERO/SIGNAL registers, period
// shadows, down-counter and the IDLE/LOW/HIGH sequencer.
// Ports:
//   clk       in  system clock
//   i_res     in  synchronous active-high reset (clears everything)
//   i_init    in  synchronous load of defaults (ZERO=0, SIGNAL=16, CTRL=0)
//   i_sel     in  this channel is addressed by the bus
//   i_ofs     in  byte offset inside the channel's 16-byte window
//   i_data    in  byte write data
//   i_we      in  byte write strobe
//   i_we32    in  32-bit write strobe (ZERO/SIGNAL byte-0 offsets only)
//   i_data32  in  32-bit write data
//   o_rdata   out combinational read byte for i_ofs (top registers it)
//   o_out     out pulse output
// Macro PWM_BURST_EN adds a 16-bit BURST register at offsets 12..13.
// ---------------------------------------------------------------------------
module pwm_channel
    import pwm_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        i_res,
    input  logic        i_init,
    input  logic        i_sel,
    input  logic [3:0]  i_ofs,
    input  logic [7:0]  i_data,
    input  logic        i_we,
    input  logic        i_we32,
    input  logic [31:0] i_data32,
    output logic [7:0]  o_rdata,
    output logic        o_out
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_zero, r_signal;
    logic [CNT_W-1:0] r_sh_zero, r_sh_signal;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en, r_oneshot, r_inv, r_done;
    state_t           r_state;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx, w_sh_zero_nx, w_sh_signal_nx;
    logic             w_start, w_period_end, w_finish, w_burst_last;
    logic             w_wr, w_wr32, w_srst;

`ifdef PWM_BURST_EN
    logic [15:0] r_burst;
    logic [15:0] r_rem;     // periods left; 0 means unlimited
    assign w_burst_last = (r_rem == 16'd1);
`else
    assign w_burst_last = 1'b0;
`endif

    // Byte write into a CNT_W-wide register; bytes above CNT_W fall away.
    function automatic logic [CNT_W-1:0] wr_byte(input logic [CNT_W-1:0] cur,
                                                 input logic [1:0] idx,
                                                 input logic [7:0] b);
        logic [31:0] t;
        t = put_byte(32'(cur), idx, b);
        return t[CNT_W-1:0];
    endfunction

    assign w_wr   = i_sel && i_we && !i_we32;
    assign w_wr32 = i_sel && i_we32;
    // SRST outranks a simultaneous 32-bit write, so it ignores i_we32.
    assign w_srst = i_sel && i_we && (i_ofs == OFS_CTRL) && i_data[CTRL_SRST];

    assign o_out = (r_state == HIGH) ^ r_inv;

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_sh_zero_nx   = r_sh_zero;
        w_sh_signal_nx = r_sh_signal;
        w_start        = 1'b0;
        w_period_end   = 1'b0;
        w_finish       = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_en && ((r_zero != '0) || (r_signal != '0))) begin
                    w_start        = 1'b1;
                    w_sh_zero_nx   = r_zero;
                    w_sh_signal_nx = r_signal;
                    if (r_zero != '0) begin
                        w_state_nx = LOW;
                        w_cnt_nx   = r_zero - ONE;
                    end else begin
                        w_state_nx = HIGH;
                        w_cnt_nx   = r_signal - ONE;
                    end
                end
            end
            LOW: begin
                if (!r_en) begin
                    w_state_nx = IDLE;
                end else if (r_cnt == '0) begin
                    if (r_sh_signal != '0) begin
                        w_state_nx = HIGH;
                        w_cnt_nx   = r_sh_signal - ONE;
                    end else begin
                        w_period_end = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - ONE;
                end
            end
            HIGH: begin
                if (!r_en) begin
                    w_state_nx = IDLE;
                end else if (r_cnt == '0) begin
                    w_period_end = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt - ONE;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // Period boundary: either finish or reload the shadows with no dead cycle.
        if (w_period_end) begin
            if (r_oneshot || w_burst_last) begin
                w_state_nx = IDLE;
                w_finish   = 1'b1;
            end else begin
                w_sh_zero_nx   = r_zero;
                w_sh_signal_nx = r_signal;
                if (r_zero != '0) begin
                    w_state_nx = LOW;
                    w_cnt_nx   = r_zero - ONE;
                end else if (r_signal != '0) begin
                    w_state_nx = HIGH;
                    w_cnt_nx   = r_signal - ONE;
                end else begin
                    w_state_nx = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_res) begin
            r_zero      <= '0;
            r_signal    <= '0;
            r_sh_zero   <= '0;
            r_sh_signal <= '0;
            r_cnt       <= '0;
            r_en        <= 1'b0;
            r_oneshot   <= 1'b0;
            r_inv       <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= IDLE;
`ifdef PWM_BURST_EN
            r_burst     <= '0;
            r_rem       <= '0;
`endif
        end else if (i_init) begin
            r_zero      <= DEF_ZERO[CNT_W-1:0];
            r_signal    <= DEF_SIGNAL[CNT_W-1:0];
            r_cnt       <= '0;
            r_en        <= 1'b0;
            r_oneshot   <= 1'b0;
            r_inv       <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= IDLE;
`ifdef PWM_BURST_EN
            r_rem       <= '0;
`endif
        end else if (w_srst) begin
            r_cnt       <= '0;
            r_en        <= 1'b0;
            r_oneshot   <= 1'b0;
            r_inv       <= 1'b0;
            r_done      <= 1'b0;
            r_state     <= IDLE;
`ifdef PWM_BURST_EN
            r_rem       <= '0;
`endif
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_sh_zero   <= w_sh_zero_nx;
            r_sh_signal <= w_sh_signal_nx;
            if (w_finish) begin
                r_done <= 1'b1;
                r_en   <= 1'b0;
            end
`ifdef PWM_BURST_EN
            if (w_start) begin
                r_rem <= r_burst;
            end else if (w_period_end && (r_rem != 16'd0)) begin
                r_rem <= r_rem - 16'd1;
            end
`endif
            // Bus writes come last so a CTRL write beats a same-cycle completion.
            if (w_wr32) begin
                if (i_ofs == OFS_ZERO) begin
                    r_zero <= i_data32[CNT_W-1:0];
                end else if (i_ofs == OFS_SIG) begin
                    r_signal <= i_data32[CNT_W-1:0];
                end
            end else if (w_wr) begin
                if (i_ofs == OFS_CTRL) begin
                    r_en      <= i_data[CTRL_EN];
                    r_oneshot <= i_data[CTRL_ONESHOT];
                    r_inv     <= i_data[CTRL_INV];
                    r_done    <= 1'b0;
                end else if (i_ofs[3:2] == OFS_ZERO[3:2]) begin
                    r_zero <= wr_byte(r_zero, i_ofs[1:0], i_data);
                end else if (i_ofs[3:2] == OFS_SIG[3:2]) begin
                    r_signal <= wr_byte(r_signal, i_ofs[1:0], i_data);
                end
`ifdef PWM_BURST_EN
                else if (i_ofs == OFS_BURST) begin
                    r_burst[7:0] <= i_data;
                end else if (i_ofs == (OFS_BURST + 4'd1)) begin
                    r_burst[15:8] <= i_data;
                end
`endif
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_ofs == OFS_CTRL) begin
            o_rdata[CTRL_EN]      = r_en;
            o_rdata[CTRL_ONESHOT] = r_oneshot;
            o_rdata[CTRL_INV]     = r_inv;
        end else if (i_ofs == OFS_STAT) begin
            o_rdata[STAT_RUN]  = (r_state != IDLE);
            o_rdata[STAT_HIGH] = (r_state == HIGH);
            o_rdata[STAT_DONE] = r_done;
`ifdef PWM_BURST_EN
            o_rdata[7:3]       = r_rem[4:0];
`endif
        end else if (i_ofs[3:2] == OFS_ZERO[3:2]) begin
            o_rdata = get_byte(32'(r_zero), i_ofs[1:0]);
        end else if (i_ofs[3:2] == OFS_SIG[3:2]) begin
            o_rdata = get_byte(32'(r_signal), i_ofs[1:0]);
        end
`ifdef PWM_BURST_EN
        else if (i_ofs == OFS_BURST) begin
            o_rdata = r_burst[7:0];
        end else if (i_ofs == (OFS_BURST + 4'd1)) begin
            o_rdata = r_burst[15:8];
        end
`endif
    end

endmodule

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
// N-channel programmable pulse generator on the 8-bit register bus.
// This level only decodes the address onto channels and registers read data.
// Ports:
//   clk        in  system clock
//   res        in  synchronous active-high reset
//   init       in  synchronous load of channel defaults
//   addr       in  register byte address (channel c at BASE_ADDR + 16*c)
//   data_in    in  byte write data
//   we         in  byte write strobe
//   we32       in  32-bit write strobe for ZERO/SIGNAL
//   data_in32  in  32-bit write data
//   data_out   out registered read data, 0 for unmapped addresses
//   out        out pulse outputs, bit c = channel c
// Macro PWM_BURST_EN enables the per-channel BURST period limit.
// ---------------------------------------------------------------------------
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         CNT_W     = 32,
    parameter logic [7:0] BASE_ADDR = 8'h50
) (
    input  logic            clk,
    input  logic            res,
    input  logic            init,
    input  logic [7:0]      addr,
    input  logic [7:0]      data_in,
    input  logic            we,
    input  logic            we32,
    input  logic [31:0]     data_in32,
    output logic [7:0]      data_out,
    output logic [N_CH-1:0] out
);

    localparam logic [4:0] NCH5 = 5'(N_CH);

    logic [7:0]      w_rel;
    logic            w_hit;
    logic [N_CH-1:0] w_sel;
    logic [7:0]      w_rd_ch [N_CH];
    logic [7:0]      w_rd;

    assign w_rel = addr - BASE_ADDR;
    assign w_hit = (addr >= BASE_ADDR) && ({1'b0, w_rel[7:4]} < NCH5);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_sel[c] = w_hit && (w_rel[7:4] == 4'(c));

        pwm_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .i_res    (res),
            .i_init   (init),
            .i_sel    (w_sel[c]),
            .i_ofs    (w_rel[3:0]),
            .i_data   (data_in),
            .i_we     (we),
            .i_we32   (we32),
            .i_data32 (data_in32),
            .o_rdata  (w_rd_ch[c]),
            .o_out    (out[c])
        );
    end

    always_comb begin
        w_rd = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_sel[c]) begin
                w_rd = w_rd_ch[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            data_out <= '0;
        end else begin
            data_out <= w_rd;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;

    logic        clk;
    logic        res;
    logic        init;
    logic [7:0]  addr;
    logic [7:0]  data_in;
    logic        we;
    logic        we32;
    logic [31:0] data_in32;
    logic [7:0]  data_out;
    logic [3:0]  pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    pwm_multi #(
        .N_CH      (4),
        .CNT_W     (32),
        .BASE_ADDR (8'h50)
    ) dut (
        .clk       (clk),
        .res       (res),
        .init      (init),
        .addr      (addr),
        .data_in   (data_in),
        .we        (we),
        .we32      (we32),
        .data_in32 (data_in32),
        .data_out  (data_out),
        .out       (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        @(negedge clk);
        we      = 1'b0;
    endtask

    task automatic wr32(input logic [7:0] a, input logic [31:0] d);
        addr      = a;
        data_in32 = d;
        we32      = 1'b1;
        @(negedge clk);
        we32      = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        @(negedge clk);
        d = data_out;
    endtask

    task automatic wait_out(input string tag, input int ch, input logic lvl);
        int n;
        n = 0;
        while ((pwm_out[ch] !== lvl) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(pwm_out[ch]), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] rv;
        logic       pat [5];
        int         hi;
        int         rises;
        logic       prev;

        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        res = 1'b1; init = 1'b0; addr = '0; data_in = '0; we = 1'b0;
        we32 = 1'b0; data_in32 = '0;
        repeat (2) @(negedge clk);
        check("reset out", 32'(pwm_out), 32'h0);
        check("reset data_out", 32'(data_out), 32'h0);
        res  = 1'b0;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        rd(8'h58, rv);
        check("init SIGNAL default", 32'(rv), 32'h10);

        // 1: ch0 ZERO=3, SIGNAL=2 continuous
        wr(8'h54, 8'd3);
        wr(8'h58, 8'd2);
        wr(8'h50, 8'h01);
        check("t1 idle after EN edge", 32'(pwm_out[0]), 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t1 cycle %0d", i), 32'(pwm_out[0]), 32'(pat[i % 5]));
        end

        // 3: SIGNAL=6 written during the first HIGH cycle
        wait_out("t3 wait low", 0, 1'b0);
        wait_out("t3 wait high", 0, 1'b1);
        wr(8'h58, 8'd6);
        check("t3 old second high", 32'(pwm_out[0]), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("t3 cycle %0d", i), 32'(pwm_out[0]),
                  ((i >= 3) && (i <= 8)) ? 32'h1 : 32'h0);
        end

        // 2: ch1 one-shot, ZERO=0, SIGNAL=4
        wr(8'h68, 8'd4);
        wr(8'h60, 8'h03);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("t2 first high", 32'(pwm_out[1]), 32'h1);
            hi += int'(pwm_out[1]);
        end
        check("t2 high count", 32'(hi), 32'd4);
        rd(8'h61, rv);
        check("t2 status done", 32'(rv), 32'h04);
        rd(8'h60, rv);
        check("t2 ctrl en cleared", 32'(rv), 32'h02);
        wr(8'h60, 8'h02);
        rd(8'h61, rv);
        check("t2 ctrl write clears done", 32'(rv), 32'h00);

        // 4: ch2 inverted output
        wr(8'h70, 8'h04);
        check("t4 inv idle level", 32'(pwm_out[2]), 32'h1);
        wr(8'h74, 8'd1);
        wr(8'h78, 8'd1);
        wr(8'h70, 8'h05);
        check("t4 idle after EN edge", 32'(pwm_out[2]), 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t4 cycle %0d", i), 32'(pwm_out[2]),
                  (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        res = 1'b1;
        @(negedge clk);
        check("t4 res out", 32'(pwm_out), 32'h0);
        check("t4 res data_out", 32'(data_out), 32'h0);
        res = 1'b0;
        rd(8'h70, rv);
        check("t4 res ctrl", 32'(rv), 32'h00);

        // 5: 32-bit write and read-back, unmapped addresses
        wr32(8'h64, 32'h0000_0102);
        rd(8'h64, rv);
        check("t5 byte0", 32'(rv), 32'h02);
        rd(8'h62, rv);
        check("t5 unmapped ofs2", 32'(rv), 32'h00);
        rd(8'h65, rv);
        check("t5 byte1", 32'(rv), 32'h01);
        rd(8'h90, rv);
        check("t5 unmapped ch4", 32'(rv), 32'h00);
        rd(8'h66, rv);
        check("t5 byte2", 32'(rv), 32'h00);
        rd(8'h64, rv);
        check("t5 byte0 again", 32'(rv), 32'h02);
        rd(8'h40, rv);
        check("t5 below base", 32'(rv), 32'h00);
        rd(8'h67, rv);
        check("t5 byte3", 32'(rv), 32'h00);

        // SRST clears INV and control
        wr(8'h70, 8'h04);
        check("srst pre inv", 32'(pwm_out[2]), 32'h1);
        wr(8'h70, 8'h84);
        check("srst out", 32'(pwm_out[2]), 32'h0);
        rd(8'h70, rv);
        check("srst ctrl", 32'(rv), 32'h00);

        // ZERO = SIGNAL = 0 with EN: stays idle
        wr(8'h80, 8'h01);
        repeat (3) @(negedge clk);
        check("zero period out", 32'(pwm_out[3]), 32'h0);
        rd(8'h81, rv);
        check("zero period status", 32'(rv), 32'h00);
        rd(8'h80, rv);
        check("zero period en kept", 32'(rv), 32'h01);
        wr(8'h80, 8'h00);

        // 6: burst register
`ifdef PWM_BURST_EN
        wr(8'h8C, 8'd3);
        wr(8'h84, 8'd1);
        wr(8'h88, 8'd1);
        wr(8'h80, 8'h01);
        rises = 0;
        prev  = pwm_out[3];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pwm_out[3] && !prev) rises++;
            prev = pwm_out[3];
        end
        check("t6 burst pulses", 32'(rises), 32'd3);
        rd(8'h81, rv);
        check("t6 burst done", 32'(rv), 32'h04);
        rd(8'h80, rv);
        check("t6 burst en cleared", 32'(rv), 32'h00);
`else
        rises = 0;
        prev  = 1'b0;
        wr(8'h6C, 8'h55);
        rd(8'h6C, rv);
        check("t6 burst ofs reads 0", 32'(rv), 32'h00);
        wr(8'h6D, 8'hAA);
        rd(8'h6D, rv);
        check("t6 burst ofs13 reads 0", 32'(rv), 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
